// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle between the execute/memory units and the register file.
//   master : requesters and stall source; drives req_valid/req_data/req_rd and
//            wb_stall, observes req_ready, pending and the registered write port.
//   slave  : the arbiter; samples the requests and stall, drives req_ready,
//            pending and the write port (reg_write_en, rd_out,
//            register_write_data, grant_id).
interface wb_port_arbiter_if #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 3,
  parameter int NREQ   = 3,
  parameter int GID_W  = 2
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ*ADDR_W-1:0] req_rd;
  logic [NREQ-1:0]        req_ready;
  logic                   wb_stall;
  logic                   reg_write_en;
  logic [ADDR_W-1:0]      rd_out;
  logic [DATA_W-1:0]      register_write_data;
  logic [GID_W-1:0]       grant_id;
  logic [NREQ-1:0]        pending;

  modport master (
    output req_valid, req_data, req_rd, wb_stall,
    input  req_ready, reg_write_en, rd_out, register_write_data, grant_id, pending
  );

  modport slave (
    input  req_valid, req_data, req_rd, wb_stall,
    output req_ready, reg_write_en, rd_out, register_write_data, grant_id, pending
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// Each of NREQ writeback sources owns a one-entry holding buffer with a
// valid/ready handshake. A round-robin arbiter drains the full buffers, one
// per cycle, into a registered write port that feeds the register file.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; empties all buffers and clears the port
//   bus    : wb_port_arbiter_if.slave (requests, stall, ready, pending, write port)
module wb_port_arbiter #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 3,
  parameter int NREQ   = 3,
  parameter int GID_W  = 2
) (
  input logic               clk,
  input logic               reset,
  wb_port_arbiter_if.slave  bus
);

  // (base + off) mod NREQ; base is always < NREQ and off <= NREQ.
  function automatic logic [GID_W-1:0] wrap_idx(input logic [GID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) begin
      s = s - NREQ;
    end else begin
      s = s + 0;
    end
    return s[GID_W-1:0];
  endfunction

  logic [NREQ-1:0]   pending_q, pending_d;
  logic [DATA_W-1:0] data_q [NREQ];
  logic [DATA_W-1:0] data_d [NREQ];
  logic [ADDR_W-1:0] rd_q [NREQ];
  logic [ADDR_W-1:0] rd_d [NREQ];
  logic [GID_W-1:0]  ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] rd_out_q, rd_out_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [GID_W-1:0]  gid_q, gid_d;

  logic [NREQ-1:0]   grant_s;
  logic              grant_vld_s;
  logic [GID_W-1:0]  gidx_s;
  logic [GID_W-1:0]  idx_s;
  logic [NREQ-1:0]   req_ready_s;

  // Round-robin search from ptr upward, first pending buffer wins.
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    gidx_s      = '0;
    idx_s       = '0;
    if (!bus.wb_stall) begin
      for (int k = 0; k < NREQ; k++) begin
        idx_s = wrap_idx(ptr_q, k);
        if (!grant_vld_s && pending_q[idx_s]) begin
          grant_vld_s     = 1'b1;
          gidx_s          = idx_s;
          grant_s[idx_s]  = 1'b1;
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end else begin
      grant_vld_s = 1'b0;
    end
  end

  // A buffer being drained this cycle can be refilled in the same cycle.
  assign req_ready_s = ~pending_q | grant_s;

  // Buffer next state: a new transfer takes priority over the drain.
  always_comb begin
    pending_d = pending_q;
    data_d    = data_q;
    rd_d      = rd_q;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && req_ready_s[i]) begin
        pending_d[i] = 1'b1;
        data_d[i]    = bus.req_data[i*DATA_W +: DATA_W];
        rd_d[i]      = bus.req_rd[i*ADDR_W +: ADDR_W];
      end else if (grant_s[i]) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  // Write port and pointer next state; payload holds when nothing is granted.
  always_comb begin
    we_d     = grant_vld_s;
    rd_out_d = rd_out_q;
    wdata_d  = wdata_q;
    gid_d    = gid_q;
    ptr_d    = ptr_q;
    if (grant_vld_s) begin
      rd_out_d = rd_q[gidx_s];
      wdata_d  = data_q[gidx_s];
      gid_d    = gidx_s;
      ptr_d    = wrap_idx(gidx_s, 1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
      end
      ptr_q    <= '0;
      we_q     <= 1'b0;
      rd_out_q <= '0;
      wdata_q  <= '0;
      gid_q    <= '0;
    end else begin
      pending_q <= pending_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
      ptr_q     <= ptr_d;
      we_q      <= we_d;
      rd_out_q  <= rd_out_d;
      wdata_q   <= wdata_d;
      gid_q     <= gid_d;
    end
  end

  assign bus.req_ready           = req_ready_s;
  assign bus.pending             = pending_q;
  assign bus.reg_write_en        = we_q;
  assign bus.rd_out              = rd_out_q;
  assign bus.register_write_data = wdata_q;
  assign bus.grant_id            = gid_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int DATA_W = 19;
  localparam int ADDR_W = 3;
  localparam int NREQ   = 3;
  localparam int GID_W  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREQ(NREQ), .GID_W(GID_W)) bus ();

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREQ(NREQ), .GID_W(GID_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic [GID_W-1:0]  gid;
    int                when;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int edge_cnt = 0;

  // Reference model: which buffers hold an entry, their contents, and the
  // round-robin starting point.
  logic [NREQ-1:0]   m_pend = '0;
  logic [DATA_W-1:0] m_data [NREQ];
  logic [ADDR_W-1:0] m_rd [NREQ];
  int                m_ptr = 0;
  logic [NREQ-1:0]   last_ready = '1;

  logic [DATA_W-1:0] tb_data [NREQ];
  logic [ADDR_W-1:0] tb_rd [NREQ];
  logic [NREQ-1:0]   cur_v = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Evaluate one cycle of the model against the DUT's combinational outputs.
  task automatic model_eval(input logic [NREQ-1:0] v, input logic st);
    int g;
    logic [NREQ-1:0] er;
    exp_t e;
    g = -1;
    if (!st) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && m_pend[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    for (int i = 0; i < NREQ; i++) er[i] = !m_pend[i] || (g == i);
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("pending", 32'(bus.pending), 32'(m_pend));
    if (g >= 0) begin
      e.rd = m_rd[g]; e.data = m_data[g]; e.gid = GID_W'(g); e.when = edge_cnt + 1;
      exp_q.push_back(e);
      m_pend[g] = 1'b0;
      m_ptr = (g + 1) % NREQ;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (v[i] && er[i]) begin
        m_pend[i] = 1'b1;
        m_data[i] = tb_data[i];
        m_rd[i]   = tb_rd[i];
      end
    end
    last_ready = er;
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic st);
    @(negedge clk);
    bus.req_valid = v;
    bus.wb_stall  = st;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[i*DATA_W +: DATA_W] = tb_data[i];
      bus.req_rd[i*ADDR_W +: ADDR_W]   = tb_rd[i];
    end
    #1;
    model_eval(v, st);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_we"}, 32'(bus.reg_write_en), 32'd0);
    chk({tag, "_rd"}, 32'(bus.rd_out), 32'd0);
    chk({tag, "_data"}, 32'(bus.register_write_data), 32'd0);
    chk({tag, "_gid"}, 32'(bus.grant_id), 32'd0);
    chk({tag, "_pending"}, 32'(bus.pending), 32'd0);
  endtask

  // Monitor: every cycle the write strobe must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      if (exp_q.size() > 0 && exp_q[0].when == edge_cnt) begin
        e = exp_q.pop_front();
        chk("write_en", 32'(bus.reg_write_en), 32'd1);
        chk("write_rd", 32'(bus.rd_out), 32'(e.rd));
        chk("write_data", 32'(bus.register_write_data), 32'(e.data));
        chk("write_gid", 32'(bus.grant_id), 32'(e.gid));
      end else begin
        chk("idle_we", 32'(bus.reg_write_en), 32'd0);
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_rd    = '0;
    bus.wb_stall  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      tb_data[i] = '0; tb_rd[i] = '0; m_data[i] = '0; m_rd[i] = '0;
    end
    #3;
    chk_cleared("rst");
    chk("rst_ready", 32'(bus.req_ready), 32'h7);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single write
    tb_data[0] = 19'h1ABCD; tb_rd[0] = 3'd5;
    step(3'b001, 1'b0);
    repeat (3) step(3'b000, 1'b0);

    // Simultaneous requesters
    for (int i = 0; i < NREQ; i++) begin
      tb_data[i] = DATA_W'(32'h100 + 32'(i)); tb_rd[i] = ADDR_W'(i + 1);
    end
    step(3'b111, 1'b0);
    repeat (4) step(3'b000, 1'b0);

    // Fairness: 0 and 2 continuously valid
    for (int k = 0; k < 8; k++) begin
      tb_data[0] = DATA_W'(32'h200 + 32'(k)); tb_data[2] = DATA_W'(32'h300 + 32'(k));
      tb_rd[0] = 3'd4; tb_rd[2] = 3'd4;
      step(3'b101, 1'b0);
    end
    repeat (4) step(3'b000, 1'b0);

    // Throughput: requester 1 back-to-back
    for (int k = 1; k <= 8; k++) begin
      tb_data[1] = DATA_W'(k); tb_rd[1] = 3'd6;
      step(3'b010, 1'b0);
      chk("thru_ready1", 32'(bus.req_ready[1]), 32'd1);
    end
    repeat (4) step(3'b000, 1'b0);

    // Stall with buffers 0 and 1 pending
    tb_data[0] = 19'h0AAAA; tb_rd[0] = 3'd7;
    tb_data[1] = 19'h05555; tb_rd[1] = 3'd7;
    step(3'b011, 1'b0);
    repeat (4) begin
      step(3'b000, 1'b1);
      chk("stall_ready", 32'(bus.req_ready), 32'h4);
    end
    repeat (4) step(3'b000, 1'b0);

    // Reset mid-operation
    for (int i = 0; i < NREQ; i++) begin
      tb_data[i] = DATA_W'(32'h7000 + 32'(i)); tb_rd[i] = ADDR_W'(i);
    end
    step(3'b111, 1'b0);
    step(3'b111, 1'b0);
    @(negedge clk);
    chk("pre_rst_pending", 32'(bus.pending), 32'h7);
    chk("pre_rst_we", 32'(bus.reg_write_en), 32'd1);
    bus.req_valid = '0;
    reset = 1'b1;
    #1;
    chk_cleared("midrst");
    m_pend = '0; m_ptr = 0; exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) step(3'b000, 1'b0);

    // Randomized traffic; a requester that was not accepted keeps its request.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(cur_v[i] && !last_ready[i])) begin
          cur_v[i]   = ($urandom_range(0, 2) != 0);
          tb_data[i] = DATA_W'($urandom);
          tb_rd[i]   = ADDR_W'($urandom_range(0, 7));
        end
      end
      step(cur_v, ($urandom_range(0, 4) == 0));
    end
    cur_v = '0;
    repeat (8) step(3'b000, 1'b0);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
